// File: rtl/midi_voice_alloc.sv
`default_nettype none
// ============================================================================
// Module      : midi_voice_alloc
// Description : MIDI channel-voice parser with running status, feeding a
//               VOICES-slot allocator (retrigger / free-first / oldest-steal).
// Revision    : 1.0 - initial release
// ============================================================================
module midi_voice_alloc #(
  parameter int unsigned VOICES  = 4,
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b0
) (
  input  logic                  CLK_50MHZ,
  input  logic                  RST_N,
  input  logic [7:0]            MIDI_BYTE,
  input  logic                  MIDI_READY,
  output logic [7*VOICES-1:0]   VOICE_NOTE,
  output logic [7*VOICES-1:0]   VOICE_VEL,
  output logic [VOICES-1:0]     VOICE_GATE,
  output logic [VOICES-1:0]     VOICE_TRIG
);

  localparam int unsigned RW = $clog2(VOICES);

  typedef enum logic [1:0] {
    NOSTAT  = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  state_t            state_q;
  logic [7:0]        rs_q;
  logic [6:0]        d1_q;
  logic [6:0]        note_q [VOICES];
  logic [6:0]        vel_q  [VOICES];
  logic [RW-1:0]     rank_q [VOICES];
  logic [VOICES-1:0] gate_q;
  logic [VOICES-1:0] trig_q;

  logic [3:0]    cmd;
  logic [6:0]    d2;
  logic          chan_ok;
  logic          exec_msg;
  logic          note_on;
  logic          note_off;
  logic          all_off;
  logic          hit_found;
  logic          free_found;
  logic [RW-1:0] hit_idx;
  logic [RW-1:0] free_idx;
  logic [RW-1:0] old_idx;
  logic [RW-1:0] sel_idx;
  logic [RW-1:0] sel_rank;

  assign cmd      = rs_q[7:4];
  assign d2       = MIDI_BYTE[6:0];
  assign chan_ok  = OMNI || (rs_q[3:0] == CHANNEL[3:0]);
  assign exec_msg = MIDI_READY && !MIDI_BYTE[7] && (state_q == WAIT_D2) && chan_ok;
  assign note_on  = exec_msg && (cmd == 4'h9) && (d2 != 7'd0);
  assign note_off = exec_msg && ((cmd == 4'h8) || ((cmd == 4'h9) && (d2 == 7'd0)));
  assign all_off  = exec_msg && (cmd == 4'hB) && ((d1_q == 7'd120) || (d1_q == 7'd123));

  // Descending scan so the last write leaves the lowest matching index.
  always_comb begin
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    old_idx    = '0;
    for (int i = int'(VOICES) - 1; i >= 0; i--) begin
      if (gate_q[i] && (note_q[i] == d1_q)) begin
        hit_found = 1'b1;
        hit_idx   = RW'(i);
      end
      if (!gate_q[i]) begin
        free_found = 1'b1;
        free_idx   = RW'(i);
      end
      if (rank_q[i] == RW'(VOICES - 1)) begin
        old_idx = RW'(i);
      end
    end
    sel_idx  = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
    sel_rank = rank_q[sel_idx];
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= NOSTAT;
      rs_q    <= '0;
      d1_q    <= '0;
      gate_q  <= '0;
      trig_q  <= '0;
      for (int i = 0; i < int'(VOICES); i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        rank_q[i] <= RW'(i);
      end
    end else begin
      trig_q <= '0;

      if (MIDI_READY) begin
        if (MIDI_BYTE >= 8'hF8) begin
          // realtime bytes are transparent to the parser
        end else if (MIDI_BYTE >= 8'hF0) begin
          rs_q    <= '0;
          state_q <= NOSTAT;
        end else if (MIDI_BYTE[7]) begin
          rs_q    <= MIDI_BYTE;
          state_q <= WAIT_D1;
        end else begin
          case (state_q)
            WAIT_D1: begin
              if ((cmd != 4'hC) && (cmd != 4'hD)) begin
                d1_q    <= MIDI_BYTE[6:0];
                state_q <= WAIT_D2;
              end
            end
            WAIT_D2: state_q <= WAIT_D1;
            default: state_q <= state_q;
          endcase
        end
      end

      if (note_on) begin
        note_q[sel_idx] <= d1_q;
        vel_q[sel_idx]  <= d2;
        gate_q[sel_idx] <= 1'b1;
        trig_q[sel_idx] <= 1'b1;
        for (int i = 0; i < int'(VOICES); i++) begin
          if (RW'(i) == sel_idx) begin
            rank_q[i] <= '0;
          end else if (rank_q[i] < sel_rank) begin
            rank_q[i] <= rank_q[i] + RW'(1);
          end
        end
      end

      if (note_off) begin
        for (int i = 0; i < int'(VOICES); i++) begin
          if (gate_q[i] && (note_q[i] == d1_q)) begin
            gate_q[i] <= 1'b0;
          end
        end
      end

      if (all_off) begin
        gate_q <= '0;
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_pack
    assign VOICE_NOTE[7*g +: 7] = note_q[g];
    assign VOICE_VEL[7*g +: 7]  = vel_q[g];
  end

  assign VOICE_GATE = gate_q;
  assign VOICE_TRIG = trig_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_voice_alloc
// Description : Directed scenarios plus random byte stream against a
//               queue-based allocation model of midi_voice_alloc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_voice_alloc;

  localparam int V = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [7:0]     mbyte;
  logic           mready;
  logic [7*V-1:0] note_o, vel_o, note_om, vel_om;
  logic [V-1:0]   gate_o, trig_o, gate_om, trig_om;

  midi_voice_alloc #(.VOICES(V), .CHANNEL(0), .OMNI(1'b0)) u_dut (
    .CLK_50MHZ (clk),
    .RST_N     (rst_n),
    .MIDI_BYTE (mbyte),
    .MIDI_READY(mready),
    .VOICE_NOTE(note_o),
    .VOICE_VEL (vel_o),
    .VOICE_GATE(gate_o),
    .VOICE_TRIG(trig_o)
  );

  midi_voice_alloc #(.VOICES(V), .CHANNEL(0), .OMNI(1'b1)) u_dut_omni (
    .CLK_50MHZ (clk),
    .RST_N     (rst_n),
    .MIDI_BYTE (mbyte),
    .MIDI_READY(mready),
    .VOICE_NOTE(note_om),
    .VOICE_VEL (vel_om),
    .VOICE_GATE(gate_om),
    .VOICE_TRIG(trig_om)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: age kept as a list of voice indices, newest first.
  int         m_st;
  logic [7:0] m_rs;
  logic [6:0] m_d1;
  logic [6:0] m_note [V];
  logic [6:0] m_vel  [V];
  logic       m_gate [V];
  logic       m_trig [V];
  int         age [$];

  task automatic m_reset();
    m_st = 0;
    m_rs = 8'h00;
    m_d1 = 7'h00;
    age  = {};
    for (int i = 0; i < V; i++) begin
      m_note[i] = 7'h00;
      m_vel[i]  = 7'h00;
      m_gate[i] = 1'b0;
      m_trig[i] = 1'b0;
      age.push_back(i);
    end
  endtask

  task automatic m_assign(input int v, input logic [6:0] n, input logic [6:0] vl);
    int pos;
    pos = 0;
    m_note[v] = n;
    m_vel[v]  = vl;
    m_gate[v] = 1'b1;
    m_trig[v] = 1'b1;
    foreach (age[j]) if (age[j] == v) pos = j;
    age.delete(pos);
    age.push_front(v);
  endtask

  task automatic m_exec(input logic [6:0] d2);
    int v;
    if (m_rs[3:0] != 4'd0) return;
    if (m_rs[7:4] == 4'h9 && d2 != 7'd0) begin
      v = -1;
      for (int i = 0; i < V; i++) if (v < 0 && m_gate[i] && m_note[i] == m_d1) v = i;
      for (int i = 0; i < V; i++) if (v < 0 && !m_gate[i]) v = i;
      if (v < 0) v = age[$];
      m_assign(v, m_d1, d2);
    end else if (m_rs[7:4] == 4'h8 || m_rs[7:4] == 4'h9) begin
      for (int i = 0; i < V; i++) if (m_gate[i] && m_note[i] == m_d1) m_gate[i] = 1'b0;
    end else if (m_rs[7:4] == 4'hB && (m_d1 == 7'd120 || m_d1 == 7'd123)) begin
      for (int i = 0; i < V; i++) m_gate[i] = 1'b0;
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_rs = 8'h00;
      m_st = 0;
    end else if (b[7]) begin
      m_rs = b;
      m_st = 1;
    end else if (m_st == 1) begin
      if (m_rs[7:4] != 4'hC && m_rs[7:4] != 4'hD) begin
        m_d1 = b[6:0];
        m_st = 2;
      end
    end else if (m_st == 2) begin
      m_st = 1;
      m_exec(b[6:0]);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      for (int i = 0; i < V; i++) m_trig[i] = 1'b0;
      if (mready) m_byte(mbyte);
    end
  end

  logic [7*V-1:0] exp_note, exp_vel;
  logic [V-1:0]   exp_gate, exp_trig;

  always @(negedge clk) begin
    for (int i = 0; i < V; i++) begin
      exp_note[7*i +: 7] = m_note[i];
      exp_vel[7*i +: 7]  = m_vel[i];
      exp_gate[i]        = m_gate[i];
      exp_trig[i]        = m_trig[i];
    end
    chk("model_note", note_o, exp_note);
    chk("model_vel",  vel_o,  exp_vel);
    chk("model_gate", gate_o, exp_gate);
    chk("model_trig", trig_o, exp_trig);
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    #1;
    mbyte  = b;
    mready = 1'b1;
    @(posedge clk);
    #1;
    mready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] gen_byte();
    int r;
    logic [7:0] st [8];
    st = '{8'h80, 8'h90, 8'h90, 8'h90, 8'hB0, 8'hC0, 8'hD0, 8'h91};
    r = $urandom_range(0, 99);
    if (r < 10) return st[$urandom_range(0, 7)];
    if (r < 13) return 8'(8'hF8 + $urandom_range(0, 7));
    if (r < 15) return 8'(8'hF0 + $urandom_range(0, 7));
    if (r < 18) return ($urandom_range(0, 1) != 0) ? 8'd120 : 8'd123;
    if (r < 38) return 8'h00;
    if (r < 75) return 8'(8'h3C + $urandom_range(0, 7));
    return 8'($urandom_range(0, 127));
  endfunction

  initial begin
    rst_n  = 1'b0;
    mbyte  = 8'h00;
    mready = 1'b0;
    m_reset();
    idle(3);
    #1;
    rst_n = 1'b1;
    idle(1);

    chk("reset_note", note_o, '0);
    chk("reset_vel",  vel_o,  '0);
    chk("reset_gate", gate_o, '0);
    chk("reset_trig", trig_o, '0);

    send(8'h90); send(8'h3C); send(8'h64);
    chk("basic_note0", note_o[6:0], 7'h3C);
    chk("basic_vel0",  vel_o[6:0],  7'h64);
    chk("basic_gate",  gate_o, 4'b0001);
    chk("basic_trig",  trig_o, 4'b0001);
    idle(1);
    chk("basic_trig_end", trig_o, 4'b0000);

    send(8'h40); send(8'h50);
    chk("rs_note1", note_o[13:7], 7'h40);
    chk("rs_vel1",  vel_o[13:7],  7'h50);
    chk("rs_gate",  gate_o, 4'b0011);
    chk("rs_note0", note_o[6:0], 7'h3C);

    send(8'h3C); send(8'h00);
    chk("v0off_gate", gate_o, 4'b0010);
    chk("v0off_note", note_o[6:0], 7'h3C);
    chk("v0off_vel",  vel_o[6:0],  7'h64);
    chk("v0off_trig", trig_o, 4'b0000);

    do_reset();
    send(8'h90);
    send(8'h3C); send(8'h64); send(8'h3E); send(8'h64);
    send(8'h40); send(8'h64); send(8'h41); send(8'h64);
    send(8'h43); send(8'h64);
    chk("steal_notes", note_o, {7'h41, 7'h40, 7'h3E, 7'h43});
    chk("steal_trig",  trig_o, 4'b0001);
    chk("steal_gate",  gate_o, 4'b1111);

    do_reset();
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
    chk("rt_note0", note_o[6:0], 7'h3C);
    chk("rt_gate",  gate_o, 4'b0001);
    chk("rt_trig",  trig_o, 4'b0001);

    do_reset();
    send(8'h91); send(8'h3C); send(8'h64);
    chk("chan_gate",  gate_o, 4'b0000);
    chk("chan_note",  note_o, '0);
    chk("omni_note0", note_om[6:0], 7'h3C);
    chk("omni_gate",  gate_om, 4'b0001);
    chk("omni_trig",  trig_om, 4'b0001);

    do_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h64);
    send(8'h40); send(8'h64);
    send(8'hB0); send(8'h7B); send(8'h00);
    chk("ctl_gate",  gate_o, 4'b0000);
    chk("ctl_notes", note_o[20:0], {7'h40, 7'h3E, 7'h3C});

    do_reset();
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    idle(1);
    chk("midrst_gate", gate_o, 4'b0000);
    chk("midrst_note", note_o, '0);
    chk("midrst_vel",  vel_o,  '0);

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else if ($urandom_range(0, 599) == 0) do_reset();
      else send(gen_byte());
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
